// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared constants and types for the three-way memory port arbiter that
//   sits in front of the processor's single-ported RAM.
//
//   Contents:
//     NUM_REQ, ADDR_W, DATA_W  default geometry of the arbiter
//     REQ_IDX_W                width of a requester index
//     REQ_PROC/LOAD/DUMP       requester index assignments
//     arb_state_e              arbiter FSM state encoding
//     arb_dbg_t                snapshot of arbiter state for debug/probing
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int NUM_REQ   = 3;
  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 8;
  localparam int REQ_IDX_W = 2;

  // Requester index assignments (bit position in req/we/gnt/rvalid).
  localparam int REQ_PROC = 0;  // processor AR path
  localparam int REQ_LOAD = 1;  // UART loader
  localparam int REQ_DUMP = 2;  // UART dumper

  // IDLE   : sample req, pick a winner, latch its command
  // ACCESS : drive the RAM with the latched command, pulse gnt
  // RDATA  : RAM read data is valid, pulse rvalid
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } arb_state_e;

  // Internal state bundled for anyone probing the arbiter hierarchically.
  typedef struct packed {
    arb_state_e             state;
    logic [REQ_IDX_W-1:0]   rr_ptr;
    logic [REQ_IDX_W-1:0]   winner;
  } arb_dbg_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Purely combinational round-robin selector. Scans the request vector
//   starting at rr_ptr and wrapping around; the first requester found wins.
//
//   Ports:
//     req     in   NUM_REQ  request vector (one bit per requester)
//     rr_ptr  in   IDX_W    index that has highest priority this round
//     valid   out  1        at least one request is pending
//     winner  out  IDX_W    index of the selected requester (0 when !valid)
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  int               k;
  logic [IDX_W-1:0] k_idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    k      = 0;
    k_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Candidate index = (rr_ptr + i) mod NUM_REQ. A single conditional
      // subtract is enough because both terms are below NUM_REQ; an out-of
      // range pointer still lands on a legal index.
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) begin
        k = k - NUM_REQ;
      end
      if (k >= NUM_REQ) begin
        k = 0;
      end
      k_idx = IDX_W'(k);
      if (!valid && req[k_idx]) begin
        valid  = 1'b1;
        winner = k_idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported RAM between three requesters (processor AR path,
//   UART loader, UART dumper) with round-robin fairness. One command is in
//   flight at a time:
//     IDLE -> ACCESS -> IDLE           write (2 cycles issue-to-issue)
//     IDLE -> ACCESS -> RDATA -> IDLE  read  (3 cycles issue-to-issue)
//
//   Handshake: a requester holds req high with its we/addr/wdata stable until
//   it sees its gnt bit; gnt is a one-cycle pulse in the ACCESS cycle and the
//   requester drops req on the edge ending that cycle. req is sampled only in
//   IDLE, so a req that vanishes before then is simply never served, and a req
//   still high in the next IDLE is a fresh request. For reads, rvalid is a
//   one-cycle pulse the following cycle and rdata is valid only while any
//   rvalid bit is high. There is no back-pressure on rvalid.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     req[2:0], we[2:0]   per-requester request and write enable
//     addr0..2, wdata0..2 per-requester command address / write data
//     gnt[2:0]            one-hot grant pulse (ACCESS cycle)
//     rvalid[2:0], rdata  one-hot read-valid pulse and read data (RDATA cycle)
//     mem_addr, mem_wdata, mem_we, mem_rdata
//                         RAM port; mem_rdata arrives one cycle after address
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = mem_port_arbiter_pkg::NUM_REQ,
  parameter int ADDR_W  = mem_port_arbiter_pkg::ADDR_W,
  parameter int DATA_W  = mem_port_arbiter_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] we,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [ADDR_W-1:0]  addr2,
  input  logic [DATA_W-1:0]  wdata0,
  input  logic [DATA_W-1:0]  wdata1,
  input  logic [DATA_W-1:0]  wdata2,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] rvalid,
  output logic [DATA_W-1:0]  rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e        state_q,  state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  win_q,    win_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic              we_q,     we_d;

  // Probe point for checkers: current state, pointer and winner in one word.
  arb_dbg_t          dbg;

  always_comb begin
    dbg        = '0;
    dbg.state  = state_q;
    dbg.rr_ptr = REQ_IDX_W'(rr_ptr_q);
    dbg.winner = REQ_IDX_W'(win_q);
  end

  // ---------------------------------------------------------------------------
  // Winner selection and command mux
  // ---------------------------------------------------------------------------
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_comb begin
    sel_addr  = addr2;
    sel_wdata = wdata2;
    if (pick_idx == IDX_W'(REQ_PROC)) begin
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end else if (pick_idx == IDX_W'(REQ_LOAD)) begin
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
    sel_we = we[pick_idx];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ACCESS;
          win_d   = pick_idx;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          we_d    = sel_we;
          // Winner drops to lowest priority for the next round.
          if (pick_idx == IDX_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = pick_idx + IDX_W'(1);
          end
        end
      end
      ST_ACCESS: begin
        state_d = we_q ? ST_IDLE : ST_RDATA;
      end
      ST_RDATA: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so they are glitch-free
  // with respect to the req inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt    = '0;
    rvalid = '0;
    rdata  = '0;
    mem_we = 1'b0;
    unique case (state_q)
      ST_ACCESS: begin
        gnt[win_q] = 1'b1;
        mem_we     = we_q;
      end
      ST_RDATA: begin
        rvalid[win_q] = 1'b1;
        rdata         = mem_rdata;
      end
      default: begin
      end
    endcase
  end

  // The latched command drives the RAM address/data at all times; only the
  // strobe is qualified by state.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
    end
  end

endmodule
